write_back_stage: RTL and testbench
===================================

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered result entries (only value 2 is supported).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  memory stage presents a retiring instruction.
REQ-005 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-006 SHALL have port in_alu_result  input  64  ALU result; also the data address.
REQ-007 SHALL have port in_mem_data  input  64  doubleword read from data memory.
REQ-008 SHALL have port in_addr_low  input  3  address bits [2:0] (byte offset within the doubleword).
REQ-009 SHALL have port in_size  input  2  load size: 00 byte, 01 half, 10 word, 11 doubleword.
REQ-010 SHALL have port in_signed  input  1  sign-extend the loaded value (LDURSB/SH/SW).
REQ-011 SHALL have port in_mem_to_reg  input  1  1 selects loaded data, 0 selects in_alu_result.
REQ-012 SHALL have port in_reg_write  input  1  instruction writes a register.
REQ-013 SHALL have port in_rd  input  5  destination register number.
REQ-014 SHALL have port out_valid  output  1  head entry presented to the register file.
REQ-015 SHALL have port out_ready  input  1  register file accepts the head entry.
REQ-016 SHALL have ports out_write_data (output, 64), out_rd (output, 5) and out_reg_write (output, 1), forming the register-file write port.
REQ-017 SHALL have port retired_count  output  32  number of entries popped since reset.

Function
REQ-018 SHALL implement a 2-entry FIFO with an occupancy count of 0..2; push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count < 2), combinationally from registered state only, never from in_valid.
REQ-020 SHALL drive out_valid = (count > 0); an entry pushed at edge N is visible at out_valid after edge N (1-cycle latency); there is no bypass.
REQ-021 SHALL, at count 1 with push and pop in the same cycle, keep count at 1 and present the new entry as head after the edge.
REQ-022 SHALL, at count 2, block pushes (in_ready=0) while still allowing pops; at count 0, ignore out_ready.
REQ-023 SHALL compute the write data at push time and store it in the entry: in_mem_to_reg=0 selects in_alu_result unchanged.
REQ-024 SHALL, when in_mem_to_reg=1, extract the loaded value from in_mem_data (little-endian) at a byte offset aligned to size: byte uses in_addr_low; half uses {in_addr_low[2:1],0}; word uses {in_addr_low[2],00}; doubleword uses 0.
REQ-025 SHALL zero-extend the extracted value to 64 bits, or sign-extend it when in_signed=1; in_signed is ignored for doubleword.
REQ-026 SHALL store out_reg_write = in_reg_write && (in_rd != 31), so writes to XZR are suppressed while the entry still flows and counts as retired.
REQ-027 SHALL drive out_write_data, out_rd and out_reg_write to 0 whenever out_valid=0.
REQ-028 SHALL increment retired_count by 1 on every pop, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-029 SHALL, while reset_n=0 and regardless of clock, force count=0, out_valid=0, out_write_data=0, out_rd=0, out_reg_write=0 and retired_count=0, with in_ready=1.
REQ-030 SHALL discard buffered entries on reset mid-operation; a push coinciding with reset assertion is lost.
REQ-031 SHALL accept a push on the first posedge after reset_n rises.

Verification
REQ-032 SHALL verify: mem_to_reg=1, size=00, signed=1, addr_low=3, mem_data=0x0000_0000_8000_0000 -> write_data=0xFFFF_FFFF_FFFF_FF80 one cycle later.
REQ-033 SHALL verify: mem_to_reg=1, size=10, signed=0, addr_low=6 (treated as offset 4), mem_data=0xDEAD_BEEF_1234_5678 -> write_data=0x0000_0000_DEAD_BEEF.
REQ-034 SHALL verify: out_ready=0 with 3 back-to-back in_valid -> in_ready drops after 2 pushes; the third is held; releasing out_ready drains in order with retired_count=3.
REQ-035 SHALL verify: count=1 with simultaneous push/pop -> count stays 1, new entry at head, no drop or duplicate.
REQ-036 SHALL verify: reg_write=1, rd=31, alu_result=0x55 -> out_valid=1, out_reg_write=0, out_rd=31, retired_count increments.
REQ-037 SHALL verify: reset_n pulsed low asynchronously with 2 entries buffered -> out_valid=0 and retired_count=0 immediately, in_ready=1.

Source files
------------

// File: rtl/write_back_stage.sv
// write_back_stage
// Two-entry result buffer between the memory stage and the register file.
// The write-back value (ALU result or size/sign-adjusted load data) is formed
// when an entry is pushed and is stored with its destination register.
// Ports:
//   clock, reset_n          - clock and asynchronous active-low reset
//   in_valid / in_ready     - push handshake from the memory stage
//   in_alu_result           - ALU result, also the data address
//   in_mem_data             - doubleword read from data memory
//   in_addr_low, in_size,
//   in_signed, in_mem_to_reg - load extraction controls
//   in_reg_write, in_rd     - register write enable and destination
//   out_valid / out_ready   - pop handshake to the register file
//   out_write_data, out_rd,
//   out_reg_write           - register-file write port (zero when idle)
//   retired_count           - entries popped since reset (wraps)
module write_back_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_alu_result,
   input  logic [63:0] in_mem_data,
   input  logic [2:0]  in_addr_low,
   input  logic [1:0]  in_size,
   input  logic        in_signed,
   input  logic        in_mem_to_reg,
   input  logic        in_reg_write,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_write_data,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic [31:0] retired_count
);

   localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

   logic [1:0]  r_count;
   logic [63:0] r_data0, r_data1;
   logic [4:0]  r_rd0, r_rd1;
   logic        r_we0, r_we1;
   logic [31:0] r_retired;

   logic [2:0]  w_off;
   logic [63:0] w_shifted;
   logic [63:0] w_load;
   logic [63:0] w_wdata;
   logic        w_we;
   logic        w_push;
   logic        w_pop;

   // Byte offset aligned down to the access size.
   always_comb begin
      w_off = '0;
      case (in_size)
         2'b00:   w_off = in_addr_low;
         2'b01:   w_off = {in_addr_low[2:1], 1'b0};
         2'b10:   w_off = {in_addr_low[2], 2'b00};
         default: w_off = '0;
      endcase
   end

   assign w_shifted = in_mem_data >> {w_off, 3'b000};

   always_comb begin
      w_load = '0;
      case (in_size)
         2'b00:   w_load = in_signed ? {{56{w_shifted[7]}},  w_shifted[7:0]}  : {56'd0, w_shifted[7:0]};
         2'b01:   w_load = in_signed ? {{48{w_shifted[15]}}, w_shifted[15:0]} : {48'd0, w_shifted[15:0]};
         2'b10:   w_load = in_signed ? {{32{w_shifted[31]}}, w_shifted[31:0]} : {32'd0, w_shifted[31:0]};
         default: w_load = w_shifted;
      endcase
   end

   assign w_wdata = in_mem_to_reg ? w_load : in_alu_result;
   // Writes to XZR still occupy a slot and retire, but never write.
   assign w_we    = in_reg_write && (in_rd != 5'd31);

   assign in_ready  = (r_count < LP_DEPTH);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Slot 0 is always the head; a pop shifts slot 1 down.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count   <= '0;
         r_data0   <= '0;
         r_data1   <= '0;
         r_rd0     <= '0;
         r_rd1     <= '0;
         r_we0     <= 1'b0;
         r_we1     <= 1'b0;
         r_retired <= '0;
      end else begin
         if (w_pop) begin
            r_retired <= r_retired + 32'd1;
         end
         if (w_push && w_pop) begin
            // Only reachable at count 1: the new entry replaces the head.
            r_data0 <= w_wdata;
            r_rd0   <= in_rd;
            r_we0   <= w_we;
         end else if (w_push) begin
            if (r_count == 2'd0) begin
               r_data0 <= w_wdata;
               r_rd0   <= in_rd;
               r_we0   <= w_we;
            end else begin
               r_data1 <= w_wdata;
               r_rd1   <= in_rd;
               r_we1   <= w_we;
            end
            r_count <= r_count + 2'd1;
         end else if (w_pop) begin
            r_data0 <= r_data1;
            r_rd0   <= r_rd1;
            r_we0   <= r_we1;
            r_count <= r_count - 2'd1;
         end
      end
   end

   assign out_write_data = out_valid ? r_data0 : '0;
   assign out_rd         = out_valid ? r_rd0   : '0;
   assign out_reg_write  = out_valid ? r_we0   : 1'b0;
   assign retired_count  = r_retired;

endmodule

// File: tb/tb_write_back_stage.sv
// Testbench for write_back_stage: table of extraction vectors, hand-written
// handshake/reset sequences, and a randomized run against a queue model.
module tb_write_back_stage;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_alu_result;
   logic [63:0] in_mem_data;
   logic [2:0]  in_addr_low;
   logic [1:0]  in_size;
   logic        in_signed;
   logic        in_mem_to_reg;
   logic        in_reg_write;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_write_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic [31:0] retired_count;

   write_back_stage #(.DEPTH(2)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_alu_result  (in_alu_result),
      .in_mem_data    (in_mem_data),
      .in_addr_low    (in_addr_low),
      .in_size        (in_size),
      .in_signed      (in_signed),
      .in_mem_to_reg  (in_mem_to_reg),
      .in_reg_write   (in_reg_write),
      .in_rd          (in_rd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_write_data (out_write_data),
      .out_rd         (out_rd),
      .out_reg_write  (out_reg_write),
      .retired_count  (retired_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        m2r;
      logic [1:0]  size;
      logic        sgn;
      logic [2:0]  al;
      logic [63:0] mem;
      logic [63:0] alu;
      logic        rw;
      logic [4:0]  rd;
      logic [63:0] exp_data;
      logic        exp_rw;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        rw;
   } ent_t;

   vec_t vecs[10];
   ent_t q[$];
   int unsigned exp_retired;

   // Reference extraction: assemble n little-endian bytes from the aligned offset.
   function automatic logic [63:0] ref_wb(input logic m2r, input logic [1:0] size,
                                          input logic sgn, input logic [2:0] al,
                                          input logic [63:0] mem, input logic [63:0] alu);
      int unsigned n, off;
      logic [63:0] val;
      if (!m2r) return alu;
      n   = 1 << size;
      off = al - (al % n);
      val = '0;
      for (int unsigned i = 0; i < n; i++)
         val = val | (64'(mem[8*(off+i) +: 8]) << (8*i));
      if (sgn && n < 8 && val[8*n-1])
         val = val - (64'd1 << (8*n));
      return val;
   endfunction

   task automatic set_in(input logic m2r, input logic [1:0] size, input logic sgn,
                         input logic [2:0] al, input logic [63:0] mem, input logic [63:0] alu,
                         input logic rw, input logic [4:0] rd);
      in_mem_to_reg = m2r;
      in_size       = size;
      in_signed     = sgn;
      in_addr_low   = al;
      in_mem_data   = mem;
      in_alu_result = alu;
      in_reg_write  = rw;
      in_rd         = rd;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic push_alu(input logic [63:0] alu, input logic [4:0] rd);
      set_in(1'b0, 2'b11, 1'b0, 3'd0, 64'd0, alu, 1'b1, rd);
   endtask

   initial begin
      logic [63:0] m;
      m = 64'h8877_6655_4433_2211;
      vecs[0] = '{m2r:1'b1, size:2'b00, sgn:1'b1, al:3'd3, mem:64'h0000_0000_8000_0000, alu:64'd0,
                  rw:1'b1, rd:5'd1, exp_data:64'hFFFF_FFFF_FFFF_FF80, exp_rw:1'b1};
      vecs[1] = '{m2r:1'b1, size:2'b10, sgn:1'b0, al:3'd6, mem:64'hDEAD_BEEF_1234_5678, alu:64'd0,
                  rw:1'b1, rd:5'd2, exp_data:64'h0000_0000_DEAD_BEEF, exp_rw:1'b1};
      vecs[2] = '{m2r:1'b1, size:2'b00, sgn:1'b0, al:3'd7, mem:m, alu:64'd0,
                  rw:1'b1, rd:5'd3, exp_data:64'h0000_0000_0000_0088, exp_rw:1'b1};
      vecs[3] = '{m2r:1'b1, size:2'b00, sgn:1'b1, al:3'd7, mem:m, alu:64'd0,
                  rw:1'b0, rd:5'd4, exp_data:64'hFFFF_FFFF_FFFF_FF88, exp_rw:1'b0};
      vecs[4] = '{m2r:1'b1, size:2'b01, sgn:1'b1, al:3'd5, mem:m, alu:64'd0,
                  rw:1'b1, rd:5'd5, exp_data:64'h0000_0000_0000_6655, exp_rw:1'b1};
      vecs[5] = '{m2r:1'b1, size:2'b01, sgn:1'b1, al:3'd7, mem:m, alu:64'd0,
                  rw:1'b1, rd:5'd6, exp_data:64'hFFFF_FFFF_FFFF_8877, exp_rw:1'b1};
      vecs[6] = '{m2r:1'b1, size:2'b10, sgn:1'b1, al:3'd3, mem:m, alu:64'd0,
                  rw:1'b1, rd:5'd7, exp_data:64'h0000_0000_4433_2211, exp_rw:1'b1};
      vecs[7] = '{m2r:1'b1, size:2'b10, sgn:1'b1, al:3'd4, mem:m, alu:64'd0,
                  rw:1'b1, rd:5'd8, exp_data:64'hFFFF_FFFF_8877_6655, exp_rw:1'b1};
      vecs[8] = '{m2r:1'b1, size:2'b11, sgn:1'b1, al:3'd5, mem:m, alu:64'd0,
                  rw:1'b1, rd:5'd31, exp_data:64'h8877_6655_4433_2211, exp_rw:1'b0};
      vecs[9] = '{m2r:1'b0, size:2'b00, sgn:1'b1, al:3'd3, mem:m, alu:64'h0123_4567_89AB_CDEF,
                  rw:1'b1, rd:5'd30, exp_data:64'h0123_4567_89AB_CDEF, exp_rw:1'b1};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_in(1'b0, 2'b00, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 5'd0);
      @(posedge clock);
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_data", out_write_data, 64'd0);
      chk("rst_rd", 64'(out_rd), 64'd0);
      chk("rst_rw", 64'(out_reg_write), 64'd0);
      chk("rst_retired", 64'(retired_count), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Table-driven extraction vectors: push, check one cycle later, pop.
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         set_in(vecs[i].m2r, vecs[i].size, vecs[i].sgn, vecs[i].al, vecs[i].mem,
                vecs[i].alu, vecs[i].rw, vecs[i].rd);
         in_valid  = 1'b1;
         out_ready = 1'b0;
         @(negedge clock);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_data", i), out_write_data, vecs[i].exp_data);
         chk($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
         chk($sformatf("vec%0d_rw", i), 64'(out_reg_write), 64'(vecs[i].exp_rw));
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
         chk($sformatf("vec%0d_idle_data", i), out_write_data, 64'd0);
         chk($sformatf("vec%0d_retired", i), 64'(retired_count), 64'(i + 1));
      end

      // Backpressure: three back-to-back pushes with out_ready low.
      do_reset();
      in_valid = 1'b1;
      push_alu(64'hA, 5'd10);
      @(negedge clock);
      chk("bp_ready_after1", 64'(in_ready), 64'd1);
      push_alu(64'hB, 5'd11);
      @(negedge clock);
      chk("bp_ready_after2", 64'(in_ready), 64'd0);
      chk("bp_head_a", out_write_data, 64'hA);
      push_alu(64'hC, 5'd12);
      @(negedge clock);
      chk("bp_held_ready", 64'(in_ready), 64'd0);
      chk("bp_held_head", out_write_data, 64'hA);
      out_ready = 1'b1;
      @(negedge clock);
      // Count 1 here: next edge pops B and pushes C simultaneously.
      chk("bp_head_b", out_write_data, 64'hB);
      chk("bp_rd_b", 64'(out_rd), 64'd11);
      chk("bp_ret1", 64'(retired_count), 64'd1);
      chk("bp_ready_cnt1", 64'(in_ready), 64'd1);
      @(negedge clock);
      in_valid = 1'b0;
      chk("pp_head_c", out_write_data, 64'hC);
      chk("pp_valid", 64'(out_valid), 64'd1);
      chk("pp_ready_cnt1", 64'(in_ready), 64'd1);
      chk("pp_ret2", 64'(retired_count), 64'd2);
      @(negedge clock);
      out_ready = 1'b0;
      chk("bp_drained", 64'(out_valid), 64'd0);
      chk("bp_ret3", 64'(retired_count), 64'd3);

      // XZR destination flows and retires without writing.
      do_reset();
      set_in(1'b0, 2'b00, 1'b0, 3'd0, 64'd0, 64'h55, 1'b1, 5'd31);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      chk("xzr_valid", 64'(out_valid), 64'd1);
      chk("xzr_rw", 64'(out_reg_write), 64'd0);
      chk("xzr_rd", 64'(out_rd), 64'd31);
      chk("xzr_data", out_write_data, 64'h55);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk("xzr_retired", 64'(retired_count), 64'd1);

      // Asynchronous reset with two entries buffered.
      in_valid = 1'b1;
      push_alu(64'h111, 5'd1);
      @(negedge clock);
      push_alu(64'h222, 5'd2);
      @(negedge clock);
      chk("ar_full", 64'(in_ready), 64'd0);
      push_alu(64'h333, 5'd3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_retired", 64'(retired_count), 64'd0);
      chk("ar_ready", 64'(in_ready), 64'd1);
      chk("ar_data", out_write_data, 64'd0);
      @(negedge clock);
      chk("ar_lost_push", 64'(out_valid), 64'd0);
      push_alu(64'h444, 5'd4);
      reset_n = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      chk("ar_first_push", 64'(out_valid), 64'd1);
      chk("ar_first_data", out_write_data, 64'h444);
      chk("ar_first_ready", 64'(in_ready), 64'd1);

      // Randomized run against a queue model.
      do_reset();
      q.delete();
      exp_retired = 0;
      for (int c = 0; c < 400; c++) begin
         ent_t e;
         bit   pu, po;
         @(negedge clock);
         chk("rnd_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("rnd_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("rnd_retired", 64'(retired_count), 64'(exp_retired));
         if (q.size() > 0) begin
            chk("rnd_data", out_write_data, q[0].data);
            chk("rnd_rd", 64'(out_rd), 64'(q[0].rd));
            chk("rnd_rw", 64'(out_reg_write), 64'(q[0].rw));
         end else begin
            chk("rnd_idle", {out_write_data[63:6], out_write_data[5:0] | 6'(out_rd) | 6'(out_reg_write)}, 64'd0);
         end
         set_in(1'($urandom), 2'($urandom), 1'($urandom), 3'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                5'($urandom_range(0, 31)));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         e.data = ref_wb(in_mem_to_reg, in_size, in_signed, in_addr_low, in_mem_data, in_alu_result);
         e.rd   = in_rd;
         e.rw   = in_reg_write && (in_rd != 5'd31);
         pu = in_valid && (q.size() < 2);
         po = out_ready && (q.size() > 0);
         @(posedge clock);
         #1;
         if (po) begin
            void'(q.pop_front());
            exp_retired++;
         end
         if (pu) q.push_back(e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 expected earlier");
      $fatal(1);
   end

endmodule
